// File: rtl/taxi_stat_pkg.sv
// rtl/taxi_stat_pkg.sv - shared types and round-robin search for statistics arbiters
package taxi_stat_pkg;

  localparam int ID_W_DEF   = 10;
  localparam int DATA_W_DEF = 16;
  localparam int RR_MAX     = 32;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [DATA_W_DEF-1:0] incr;
  } stat_incr_t;

  // First set bit of mask strictly after ptr, wrapping over n entries; 0 when mask is empty.
  function automatic int rr_next(input logic [RR_MAX-1:0] mask, input int ptr, input int n,
                                 input bit lsb_high);
    int idx;
    int res;
    res = 0;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = lsb_high ? ptr - k : ptr + k;
        if (idx < 0) begin
          idx = idx + n;
        end else if (idx >= n) begin
          idx = idx - n;
        end
        if (mask[idx[$clog2(RR_MAX)-1:0]]) begin
          res = idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// rtl/taxi_axis_if.sv - AXI-Stream bundle with source and sink views
interface taxi_axis_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 10,
  parameter int USER_W = 1
) ();
  localparam int KEEP_W = (DATA_W + 7) / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport src (output tdata, tkeep, tlast, tid, tuser, tvalid, input tready);
  modport snk (input tdata, tkeep, tlast, tid, tuser, tvalid, output tready);
endinterface

// File: rtl/taxi_axis_stat_merge_slot.sv
// rtl/taxi_axis_stat_merge_slot.sv - one-entry accumulator that sums same-ID increments
module taxi_axis_stat_merge_slot #(
  parameter int DATA_W      = 16,
  parameter int ID_W        = 10,
  parameter bit COALESCE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [ID_W-1:0]   s_tid,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              pop,
  output logic              slot_vld,
  output logic [ID_W-1:0]   slot_id,
  output logic [DATA_W-1:0] slot_acc,
  output logic              stat_coalesce
);

  logic              vld_q, vld_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              coal_q, coal_d;
  logic [DATA_W:0]   sum;
  logic              match;
  logic              load;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, s_tdata};
    // A carry means the merged count would not fit: hold the source until the slot drains.
    match    = COALESCE_EN && vld_q && (s_tid == id_q) && !sum[DATA_W];
    s_tready = !vld_q || pop || match;
    load     = s_tvalid && (!vld_q || pop);
    vld_d    = vld_q && !pop;
    id_d     = id_q;
    acc_d    = acc_q;
    coal_d   = 1'b0;
    if (load) begin
      vld_d = 1'b1;
      id_d  = s_tid;
      acc_d = s_tdata;
    end else if (s_tvalid && match) begin
      acc_d  = sum[DATA_W-1:0];
      coal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      acc_q  <= '0;
      coal_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      acc_q  <= acc_d;
      coal_q <= coal_d;
    end
  end

  assign slot_vld      = vld_q;
  assign slot_id       = id_q;
  assign slot_acc      = acc_q;
  assign stat_coalesce = coal_q;

endmodule

// File: rtl/taxi_axis_stat_merge.sv
// rtl/taxi_axis_stat_merge.sv - round-robin merge of coalescing statistics increment streams
module taxi_axis_stat_merge
  import taxi_stat_pkg::*;
#(
  parameter int S_COUNT           = 4,
  parameter int DATA_W            = 16,
  parameter int ID_W              = 10,
  parameter bit COALESCE_EN       = 1'b1,
  parameter bit ARB_LSB_HIGH_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  taxi_axis_if.snk           s_axis [S_COUNT],
  taxi_axis_if.src           m_axis,
  output logic [S_COUNT-1:0] stat_coalesce
);

  localparam int PTR_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  logic [S_COUNT-1:0] slot_vld;
  logic [S_COUNT-1:0] pop;
  logic [DATA_W-1:0]  slot_acc [S_COUNT];
  logic [ID_W-1:0]    slot_id  [S_COUNT];

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gnt;
  logic              m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic [ID_W-1:0]   m_tid_q, m_tid_d;
  logic              load_en;
  logic              any_vld;

  for (genvar i = 0; i < S_COUNT; i++) begin : g_slot
    logic s_tready;

    taxi_axis_stat_merge_slot #(
      .DATA_W      (DATA_W),
      .ID_W        (ID_W),
      .COALESCE_EN (COALESCE_EN)
    ) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_tdata       (s_axis[i].tdata),
      .s_tid         (s_axis[i].tid),
      .s_tvalid      (s_axis[i].tvalid),
      .s_tready      (s_tready),
      .pop           (pop[i]),
      .slot_vld      (slot_vld[i]),
      .slot_id       (slot_id[i]),
      .slot_acc      (slot_acc[i]),
      .stat_coalesce (stat_coalesce[i])
    );

    assign s_axis[i].tready = s_tready;
  end

  // Grants use registered slot state only, so a slot filled this cycle waits one cycle.
  always_comb begin
    load_en    = !m_tvalid_q || m_axis.tready;
    any_vld    = |slot_vld;
    gnt        = PTR_W'(rr_next(RR_MAX'(slot_vld), int'(ptr_q), S_COUNT, ARB_LSB_HIGH_PRIO));
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tid_d    = m_tid_q;
    ptr_d      = ptr_q;
    for (int i = 0; i < S_COUNT; i++) begin
      pop[i] = load_en && any_vld && (gnt == PTR_W'(i));
    end
    if (load_en) begin
      m_tvalid_d = any_vld;
      if (any_vld) begin
        m_tdata_d = slot_acc[gnt];
        m_tid_d   = slot_id[gnt];
        ptr_d     = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= '0;
      ptr_q      <= PTR_W'(S_COUNT - 1);
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tid_q    <= m_tid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tid    = m_tid_q;
  assign m_axis.tlast  = 1'b1;
  assign m_axis.tkeep  = '1;
  assign m_axis.tuser  = '0;

endmodule

// File: tb/tb_taxi_axis_stat_merge.sv
// tb/tb_taxi_axis_stat_merge.sv - directed and randomized bench for taxi_axis_stat_merge
module tb_taxi_axis_stat_merge;

  localparam int S  = 4;
  localparam int DW = 16;
  localparam int IW = 10;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] d;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata  [S];
  logic [IW-1:0] s_tid    [S];
  logic          s_tvalid [S];
  logic          s_tready [S];
  logic          m_tready, m_tvalid, m_tlast;
  logic [0:0]    m_tuser;
  logic [DW-1:0] m_tdata;
  logic [IW-1:0] m_tid;
  logic [S-1:0]  stat_coalesce;

  logic [DW-1:0] b_tdata;
  logic [IW-1:0] b_tid;
  logic          b_tvalid, b_tready;
  logic          mb_tready, mb_tvalid;
  logic [DW-1:0] mb_tdata;
  logic [IW-1:0] mb_tid;
  logic [S-1:0]  stat_coalesce_b;

  taxi_axis_if #(.DATA_W(DW), .ID_W(IW)) s_if  [S] ();
  taxi_axis_if #(.DATA_W(DW), .ID_W(IW)) m_if      ();
  taxi_axis_if #(.DATA_W(DW), .ID_W(IW)) sb_if [S] ();
  taxi_axis_if #(.DATA_W(DW), .ID_W(IW)) mb_if     ();

  for (genvar g = 0; g < S; g++) begin : g_src
    assign s_if[g].tdata   = s_tdata[g];
    assign s_if[g].tid     = s_tid[g];
    assign s_if[g].tvalid  = s_tvalid[g];
    assign s_if[g].tkeep   = '1;
    assign s_if[g].tlast   = 1'b1;
    assign s_if[g].tuser   = '0;
    assign s_tready[g]     = s_if[g].tready;
    assign sb_if[g].tdata  = (g == 2) ? b_tdata : '0;
    assign sb_if[g].tid    = (g == 2) ? b_tid : '0;
    assign sb_if[g].tvalid = (g == 2) && b_tvalid;
    assign sb_if[g].tkeep  = '1;
    assign sb_if[g].tlast  = 1'b1;
    assign sb_if[g].tuser  = '0;
  end
  assign b_tready = sb_if[2].tready;

  assign m_if.tready  = m_tready;
  assign m_tvalid     = m_if.tvalid;
  assign m_tdata      = m_if.tdata;
  assign m_tid        = m_if.tid;
  assign m_tlast      = m_if.tlast;
  assign m_tuser      = m_if.tuser;
  assign mb_if.tready = mb_tready;
  assign mb_tvalid    = mb_if.tvalid;
  assign mb_tdata     = mb_if.tdata;
  assign mb_tid       = mb_if.tid;

  taxi_axis_stat_merge #(
    .S_COUNT(S), .DATA_W(DW), .ID_W(IW), .COALESCE_EN(1'b1), .ARB_LSB_HIGH_PRIO(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if), .stat_coalesce(stat_coalesce)
  );

  taxi_axis_stat_merge #(
    .S_COUNT(S), .DATA_W(DW), .ID_W(IW), .COALESCE_EN(1'b0), .ARB_LSB_HIGH_PRIO(1'b0)
  ) dut_nc (
    .clk(clk), .rst_n(rst_n), .s_axis(sb_if), .m_axis(mb_if), .stat_coalesce(stat_coalesce_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic          acc_x [S+1];
  logic [25:0]   beat_q [$];
  int            beat_cyc [$];
  logic [25:0]   beat_b [$];
  logic [25:0]   exp_q [$];
  ent_t          mq [S][$];
  int            coal_cnt [S];
  int            coal_b = 0;
  int            cyc = 0;
  bit            rnd_on = 1'b0;
  bit            stall_prev = 1'b0;
  logic [25:0]   prev_beat = '0;
  int            n_acc = 0;
  int            n_beat = 0;
  int            n_coal = 0;

  // Beat must equal the sum of a run of same-ID increments taken in order from that input.
  task automatic model_beat(input logic [IW-1:0] tid, input logic [DW-1:0] td);
    int          src;
    int unsigned sum;
    ent_t        e;
    bit          done;
    src  = int'(tid) / 8;
    sum  = 0;
    done = 1'b0;
    chk("rnd_src", 64'(src < S), 64'd1);
    if (src < S) begin
      do begin
        if (mq[src].size() == 0) begin
          chk("rnd_underrun", 64'(mq[src].size()), 64'd1);
          done = 1'b1;
        end else begin
          e = mq[src].pop_front();
          chk("rnd_id", 64'(e.id), 64'(tid));
          sum = sum + 32'(e.d);
        end
      end while (!done && sum < 32'(td));
      chk("rnd_sum", 64'(sum), 64'(td));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < S; i++) acc_x[i] = s_tvalid[i] && s_tready[i];
    acc_x[S] = b_tvalid && b_tready;
    if (m_tvalid && m_tready) begin
      beat_q.push_back({m_tid, m_tdata});
      beat_cyc.push_back(cyc);
    end
    if (mb_tvalid && mb_tready) beat_b.push_back({mb_tid, mb_tdata});
    if (stat_coalesce_b != '0) coal_b++;
    for (int i = 0; i < S; i++) if (stat_coalesce[i]) coal_cnt[i]++;
    if (rnd_on) begin
      for (int i = 0; i < S; i++) begin
        if (acc_x[i]) begin
          mq[i].push_back({s_tid[i], s_tdata[i]});
          n_acc++;
        end
        if (stat_coalesce[i]) n_coal++;
      end
      if (stall_prev) begin
        chk("hold_vld", 64'(m_tvalid), 64'd1);
        chk("hold_beat", 64'({m_tid, m_tdata}), 64'(prev_beat));
      end
      stall_prev = m_tvalid && !m_tready;
      prev_beat  = {m_tid, m_tdata};
      if (m_tvalid && m_tready) begin
        n_beat++;
        model_beat(m_tid, m_tdata);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int id, input int d);
    if (i == S) begin
      b_tvalid = 1'b1;
      b_tid    = IW'(id);
      b_tdata  = DW'(d);
    end else begin
      s_tvalid[i] = 1'b1;
      s_tid[i]    = IW'(id);
      s_tdata[i]  = DW'(d);
    end
  endtask

  task automatic wait_acc(input int i, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_x[i] && n < 40);
    chk("acc_done", 64'(acc_x[i]), 64'd1);
  endtask

  task automatic chk_beats(input string tag, input bit use_b);
    int sz;
    sz = use_b ? beat_b.size() : beat_q.size();
    chk({tag, "_n"}, 64'(sz), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < sz) chk(tag, 64'(use_b ? beat_b[k] : beat_q[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic prefill();
    int n;
    m_tready = 1'b0;
    drive(0, 100, 1);
    wait_acc(0, n);
    s_tvalid[0] = 1'b0;
    repeat (2) cycle();
    chk("prefill_vld", 64'(m_tvalid), 64'd1);
    beat_q.delete();
  endtask

  initial begin
    int  n;
    int  first_acc;
    bit  seen;
    m_tready  = 1'b0;
    mb_tready = 1'b0;
    b_tvalid  = 1'b0;
    b_tdata   = '0;
    b_tid     = '0;
    for (int i = 0; i < S; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = '0;
      s_tid[i]    = '0;
      coal_cnt[i] = 0;
    end
    for (int i = 0; i <= S; i++) acc_x[i] = 1'b0;

    repeat (3) cycle();
    chk("rst_vld", 64'(m_tvalid), 64'd0);
    chk("rst_data", 64'(m_tdata), 64'd0);
    chk("rst_id", 64'(m_tid), 64'd0);
    chk("rst_coal", 64'(stat_coalesce), 64'd0);
    chk("rst_nc_vld", 64'(mb_tvalid), 64'd0);
    chk("tlast", 64'(m_tlast), 64'd1);
    chk("tuser", 64'(m_tuser), 64'd0);
    for (int i = 0; i < S; i++) chk("rst_rdy", 64'(s_tready[i]), 64'd1);
    rst_n = 1'b1;

    // Three same-ID increments fold into one beat while the output is stalled.
    prefill();
    coal_cnt[2] = 0;
    drive(2, 5, 3);
    wait_acc(2, n);
    chk("coal_lat0", 64'(n), 64'd1);
    drive(2, 5, 4);
    wait_acc(2, n);
    chk("coal_lat1", 64'(n), 64'd1);
    drive(2, 5, 10);
    wait_acc(2, n);
    chk("coal_lat2", 64'(n), 64'd1);
    s_tvalid[2] = 1'b0;
    repeat (2) cycle();
    chk("coal_pulses", 64'(coal_cnt[2]), 64'd2);
    m_tready = 1'b1;
    repeat (4) cycle();
    exp_q.delete();
    exp_q.push_back({10'd100, 16'd1});
    exp_q.push_back({10'd5, 16'd17});
    chk_beats("coal", 1'b0);

    prefill();
    drive(1, 7, 16'hFFF0);
    wait_acc(1, n);
    drive(1, 7, 16'h0020);
    seen = 1'b0;
    repeat (4) begin
      cycle();
      seen = seen | acc_x[1];
    end
    chk("ovf_noacc", 64'(seen), 64'd0);
    chk("ovf_rdy", 64'(s_tready[1]), 64'd0);
    m_tready = 1'b1;
    wait_acc(1, n);
    s_tvalid[1] = 1'b0;
    repeat (5) cycle();
    exp_q.delete();
    exp_q.push_back({10'd100, 16'd1});
    exp_q.push_back({10'd7, 16'hFFF0});
    exp_q.push_back({10'd7, 16'h0020});
    chk_beats("ovf", 1'b0);

    prefill();
    drive(3, 3, 9);
    wait_acc(3, n);
    drive(3, 4, 0);
    repeat (3) cycle();
    chk("diff_rdy", 64'(s_tready[3]), 64'd0);
    m_tready = 1'b1;
    wait_acc(3, n);
    s_tvalid[3] = 1'b0;
    repeat (5) cycle();
    exp_q.delete();
    exp_q.push_back({10'd100, 16'd1});
    exp_q.push_back({10'd3, 16'd9});
    exp_q.push_back({10'd4, 16'd0});
    chk_beats("diff", 1'b0);

    drive(S, 5, 3);
    wait_acc(S, n);
    drive(S, 5, 4);
    wait_acc(S, n);
    drive(S, 5, 10);
    repeat (3) cycle();
    chk("nc_rdy", 64'(b_tready), 64'd0);
    mb_tready = 1'b1;
    wait_acc(S, n);
    b_tvalid = 1'b0;
    repeat (5) cycle();
    exp_q.delete();
    exp_q.push_back({10'd5, 16'd3});
    exp_q.push_back({10'd5, 16'd4});
    exp_q.push_back({10'd5, 16'd10});
    chk_beats("nc", 1'b1);
    chk("nc_coal", 64'(coal_b), 64'd0);

    // Asynchronous reset with data in flight, then fairness from a clean pointer.
    m_tready = 1'b0;
    for (int i = 0; i < S; i++) drive(i, 40 + i, 1 + i);
    cycle();
    for (int i = 0; i < S; i++) s_tvalid[i] = 1'b0;
    repeat (2) cycle();
    chk("pre_rst_vld", 64'(m_tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 64'(m_tvalid), 64'd0);
    chk("rst_async_data", 64'(m_tdata), 64'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < S; i++) chk("rst_rel_rdy", 64'(s_tready[i]), 64'd1);
    beat_q.delete();
    beat_cyc.delete();
    for (int i = 0; i < S; i++) drive(i, 20 + i, 1);
    m_tready  = 1'b1;
    first_acc = -1;
    repeat (12) begin
      cycle();
      if (first_acc < 0 && acc_x[0]) first_acc = cyc - 1;
    end
    chk("fair_n", 64'(beat_q.size() >= 8), 64'd1);
    if (beat_q.size() >= 8) begin
      chk("fair_lat", 64'(beat_cyc[0] - first_acc), 64'd2);
      for (int k = 0; k < 8; k++) begin
        chk("fair_tid", 64'(beat_q[k][25:16]), 64'(20 + k % 4));
        chk("fair_cyc", 64'(beat_cyc[k]), 64'(beat_cyc[0] + k));
      end
    end
    for (int i = 0; i < S; i++) s_tvalid[i] = 1'b0;
    repeat (10) cycle();

    rnd_on     = 1'b1;
    stall_prev = 1'b0;
    repeat (1500) begin
      for (int i = 0; i < S; i++) begin
        if (!s_tvalid[i] || acc_x[i]) begin
          s_tvalid[i] = ($urandom_range(0, 9) < 7);
          s_tid[i]    = IW'(i * 8 + int'($urandom_range(0, 1)));
          s_tdata[i]  = ($urandom_range(0, 3) == 0) ? DW'(32'hF000 + $urandom_range(0, 4095))
                                                    : DW'($urandom_range(1, 40));
        end
      end
      m_tready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    repeat (100) begin
      for (int i = 0; i < S; i++) if (acc_x[i]) s_tvalid[i] = 1'b0;
      m_tready = 1'b1;
      cycle();
    end
    rnd_on = 1'b0;
    for (int i = 0; i < S; i++) chk("rnd_left", 64'(mq[i].size()), 64'd0);
    chk("rnd_count", 64'(n_acc), 64'(n_beat + n_coal));
    chk("rnd_idle", 64'(m_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
